// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU : 2-bit operation encodings on `op`
//   - md_state_e                      : control FSM states (idle, stepping, fix-up)
//   - SEL_HI/SEL_LO                   : HI/LO select used for both MTxx and MFxx
//   - op_is_div/op_is_signed          : decode helpers for the op encoding
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  localparam logic SEL_HI = 1'b0;
  localparam logic SEL_LO = 1'b1;

  // Upper op bit selects divide, lower op bit selects the unsigned variant.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// -----------------------------------------------------------------------------
// muldiv_iter_core
// Datapath of the iterative multiplier/divider. Operands are reduced to
// magnitudes at load time, one radix-2 step runs per cycle while step_i is
// high, and the signed/zero-divisor fix-up is applied combinationally on the
// result outputs so the controller can capture them in its fix-up cycle.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   load_i            : latch operands, op kind and result sign flags
//   step_i            : perform one shift-add / shift-subtract step
//   op_i              : operation encoding (muldiv_pkg)
//   src_a_i, src_b_i  : multiplicand/dividend, multiplier/divisor
//   res_hi_o/res_lo_o : fixed-up HI/LO result (valid after XLEN steps)
//   dbz_o             : latched operation was a divide by zero
// -----------------------------------------------------------------------------
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic [XLEN-1:0] res_hi_o,
  output logic [XLEN-1:0] res_lo_o,
  output logic            dbz_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   a_raw_q;
  logic              is_div_q;
  logic              neg_lo_q;
  logic              neg_hi_q;
  logic              b_zero_q;

  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;

  // Operand magnitudes. -MIN wraps back to MIN, which is exactly the
  // unsigned magnitude 2^(XLEN-1), so MIN needs no special case.
  always_comb begin
    a_neg = op_is_signed(op_i) & src_a_i[XLEN-1];
    b_neg = op_is_signed(op_i) & src_b_i[XLEN-1];
    a_abs = a_neg ? -src_a_i : src_a_i;
    b_abs = b_neg ? -src_b_i : src_b_i;
  end

  // One step of each algorithm. Multiply consumes the multiplier from the
  // low half of the accumulator LSB first while the partial product grows in
  // the high half. Divide shifts the dividend out of the low half into the
  // remainder and shifts quotient bits in behind it. The shifted remainder is
  // below twice the divisor, so after a successful subtract it fits in XLEN
  // bits and a plain XLEN-bit subtraction gives the right value.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_ge   = rem_sh[XLEN] | (rem_sh[XLEN-1:0] >= opnd_q);
    rem_new  = rem_ge ? (rem_sh[XLEN-1:0] - opnd_q) : rem_sh[XLEN-1:0];
    div_next = {rem_new, acc_q[XLEN-2:0], rem_ge};
  end

  // Operand/accumulator registers. Load primes the accumulator with the
  // multiplier (multiply) or dividend (divide) in the low half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      b_zero_q <= 1'b0;
    end else if (load_i) begin
      is_div_q <= op_is_div(op_i);
      a_raw_q  <= src_a_i;
      b_zero_q <= (src_b_i == '0);
      neg_lo_q <= a_neg ^ b_neg;
      if (op_is_div(op_i)) begin
        acc_q    <= {{XLEN{1'b0}}, a_abs};
        opnd_q   <= b_abs;
        neg_hi_q <= a_neg;
      end else begin
        acc_q    <= {{XLEN{1'b0}}, b_abs};
        opnd_q   <= a_abs;
        neg_hi_q <= a_neg ^ b_neg;
      end
    end else if (step_i) begin
      acc_q <= is_div_q ? div_next : mul_next;
    end
  end

  // Sign fix-up and divide-by-zero override. The zero-divisor result is
  // produced here directly instead of relying on what the step logic leaves.
  always_comb begin
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    dbz_o    = is_div_q & b_zero_q;
    if (!is_div_q) begin
      res_hi_o = prod_fix[2*XLEN-1:XLEN];
      res_lo_o = prod_fix[XLEN-1:0];
    end else if (b_zero_q) begin
      res_hi_o = a_raw_q;
      res_lo_o = '1;
    end else begin
      res_hi_o = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      res_lo_o = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// -----------------------------------------------------------------------------
// muldiv_hilo_unit
// Execute-stage multiply/divide unit with architectural HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU over XLEN+1 cycles, handles MTHI/MTLO writes and
// MFHI/MFLO reads, and stalls the pipeline when it touches HI/LO mid-operation.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start, op       : begin op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b    : multiplicand/dividend, multiplier/divisor
//   flush           : cancel a pending start or in-flight operation
//   hilo_we         : MTHI/MTLO write strobe, data on hilo_wdata
//   hilo_wsel       : 0 = HI, 1 = LO for both write and read
//   rd_req          : MFHI/MFLO in execute
//   rd_data         : combinational HI or LO per hilo_wsel
//   busy, stall     : operation in flight / pipeline hold request
//   done            : one-cycle pulse after HI/LO were updated by an op
//   div_by_zero     : pulses with done for a zero divisor
// -----------------------------------------------------------------------------
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  input  logic            hilo_we,
  input  logic            hilo_wsel,
  input  logic [XLEN-1:0] hilo_wdata,
  input  logic            rd_req,
  output logic [XLEN-1:0] rd_data,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic            div_by_zero
);

  localparam int CNT_W = $clog2(XLEN + 1);

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;

  logic            core_load;
  logic            core_step;
  logic [XLEN-1:0] core_hi;
  logic [XLEN-1:0] core_lo;
  logic            core_dbz;

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_i  (core_load),
    .step_i  (core_step),
    .op_i    (op),
    .src_a_i (src_a),
    .src_b_i (src_b),
    .res_hi_o(core_hi),
    .res_lo_o(core_lo),
    .dbz_o   (core_dbz)
  );

  // Control: accept in idle (start beats a same-cycle MTxx write), step for
  // XLEN cycles, then commit the fixed-up result. A flush in either busy
  // state abandons the operation before anything is committed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          core_load = 1'b1;
          cnt_d     = '0;
          state_d   = MD_RUN;
        end else if (hilo_we) begin
          if (hilo_wsel == SEL_LO) lo_d = hilo_wdata;
          else                     hi_d = hilo_wdata;
        end
      end
      MD_RUN: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          core_step = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (!flush) begin
          hi_d   = core_hi;
          lo_d   = core_lo;
          done_d = 1'b1;
          dbz_d  = core_dbz;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Control and architectural state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Pipeline-facing outputs; stall is purely combinational so a request is
  // held off in the very cycle it appears.
  always_comb begin
    busy        = (state_q != MD_IDLE);
    stall       = busy & (rd_req | start | hilo_we);
    rd_data     = (hilo_wsel == SEL_LO) ? lo_q : hi_q;
    done        = done_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_hilo_unit
// Self-checking bench for muldiv_hilo_unit (XLEN = 32): a table of operations
// run back to back through a result scoreboard, followed by hand-written
// sequences for stalls, MTHI/MTLO interaction, flush and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            hilo_we;
  logic            hilo_wsel;
  logic [XLEN-1:0] hilo_wdata;
  logic            rd_req;
  logic [XLEN-1:0] rd_data;
  logic            busy;
  logic            stall;
  logic            done;
  logic            div_by_zero;

  muldiv_hilo_unit #(
    .XLEN(XLEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .hilo_we    (hilo_we),
    .hilo_wsel  (hilo_wsel),
    .hilo_wdata (hilo_wdata),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDbz;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];
  exp_t sbQ[$];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired or scoreboard empty", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drive start for one cycle and record the expected result. Returns 2 time
  // units after the accept edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eHi, input logic [31:0] eLo, input logic eDbz);
    exp_t e;
    e.hi  = eHi;
    e.lo  = eLo;
    e.dbz = eDbz;
    sbQ.push_back(e);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  // Counts busy cycles until done appears (sampled at negedge).
  task automatic waitDone(input string name, output int busyCycles, output bit ok);
    busyCycles = 0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) checkOutput({name, "_done_single_pulse"}, {63'd0, done}, 64'd0);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busyCycles++;
    end
    if (!ok) failNow({name, "_done_timeout"});
  endtask

  // Pops the scoreboard and compares HI, LO and div_by_zero in the done cycle.
  task automatic compareResult(input string name);
    exp_t e;
    if (sbQ.size() == 0) begin
      failNow({name, "_scoreboard"});
    end else begin
      e = sbQ.pop_front();
      hilo_wsel = SEL_LO;
      #1;
      checkOutput({name, "_lo"}, {32'd0, rd_data}, {32'd0, e.lo});
      hilo_wsel = SEL_HI;
      #1;
      checkOutput({name, "_hi"}, {32'd0, rd_data}, {32'd0, e.hi});
      checkOutput({name, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
    end
  endtask

  task automatic readBoth(input string name, input logic [31:0] eHi, input logic [31:0] eLo);
    hilo_wsel = SEL_HI;
    #1;
    checkOutput({name, "_hi"}, {32'd0, rd_data}, {32'd0, eHi});
    hilo_wsel = SEL_LO;
    #1;
    checkOutput({name, "_lo"}, {32'd0, rd_data}, {32'd0, eLo});
  endtask

  initial begin
    int bc;
    bit ok;
    int doneSeen;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, "mult_m3x5"};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"};
    vecs[2]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_minxmin"};
    vecs[3]  = '{MD_MULT,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, "mult_7xm2"};
    vecs[4]  = '{MD_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, "multu_shift"};
    vecs[5]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "divu_100_7"};
    vecs[6]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2"};
    vecs[7]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_min_m1"};
    vecs[8]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, "div_7_m2"};
    vecs[9]  = '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, "divu_5_0"};
    vecs[10] = '{MD_DIV,   32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1, "div_m9_0"};
    vecs[11] = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, "divu_max_1"};
    vecs[12] = '{MD_DIVU,  32'h80000000, 32'd3,        32'd2,        32'h2AAAAAAA, 1'b0, "divu_big_3"};

    rst        = 1'b1;
    start      = 1'b0;
    op         = MD_MULT;
    src_a      = '0;
    src_b      = '0;
    flush      = 1'b0;
    hilo_we    = 1'b0;
    hilo_wsel  = SEL_HI;
    hilo_wdata = '0;
    rd_req     = 1'b0;
    #1 rst = 1'b0;

    // Reset state
    tick(2);
    @(negedge clk);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    readBoth("reset", 32'd0, 32'd0);
    tick(1);
    rst = 1'b1;
    tick(1);

    // Table: each start is driven in the previous done cycle (no bubble).
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, vecs[i].expDbz);
      waitDone(vecs[i].name, bc, ok);
      checkOutput({vecs[i].name, "_busy_cycles"}, 64'(bc), 64'(XLEN + 1));
      if (ok) compareResult(vecs[i].name);
      else void'(sbQ.pop_front());
    end

    // MTLO in idle, then MFLO stalled mid-operation.
    tick(1);
    hilo_we    = 1'b1;
    hilo_wsel  = SEL_LO;
    hilo_wdata = 32'h0BADF00D;
    tick(1);
    hilo_we = 1'b0;
    @(negedge clk);
    checkOutput("mtlo_idle", {32'd0, rd_data}, {32'd0, 32'h0BADF00D});
    applyStimulus(MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    tick(2);
    rd_req    = 1'b1;
    hilo_wsel = SEL_LO;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      checkOutput("mflo_stall", {63'd0, stall}, 64'd1);
      checkOutput("mflo_old_lo", {32'd0, rd_data}, {32'd0, 32'h0BADF00D});
    end
    if (!ok) failNow("mflo_done_timeout");
    checkOutput("mflo_done_stall", {63'd0, stall}, 64'd0);
    checkOutput("mflo_done_data", {32'd0, rd_data}, {32'd0, 32'd42});
    rd_req = 1'b0;
    if (ok) compareResult("mflo_op");
    else void'(sbQ.pop_front());

    // MTHI while busy is ignored; held into the done cycle it lands.
    applyStimulus(MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    hilo_we    = 1'b1;
    hilo_wsel  = SEL_HI;
    hilo_wdata = 32'h1234;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      checkOutput("mthi_busy_stall", {63'd0, stall}, 64'd1);
      checkOutput("mthi_busy_hi", {32'd0, rd_data}, 64'd0);
    end
    if (!ok) failNow("mthi_done_timeout");
    checkOutput("mthi_done_stall", {63'd0, stall}, 64'd0);
    checkOutput("mthi_done_hi", {32'd0, rd_data}, 64'd0);
    void'(sbQ.pop_front());
    tick(1);
    hilo_we = 1'b0;
    @(negedge clk);
    checkOutput("mthi_after_done", {32'd0, rd_data}, {32'd0, 32'h1234});

    // start and MTHI together in idle: start wins, write dropped.
    tick(1);
    hilo_we    = 1'b1;
    hilo_wsel  = SEL_HI;
    hilo_wdata = 32'h5555;
    applyStimulus(MD_MULTU, 32'h10000, 32'h10000, 32'd1, 32'd0, 1'b0);
    hilo_we = 1'b0;
    @(negedge clk);
    checkOutput("start_wins_busy", {63'd0, busy}, 64'd1);
    checkOutput("start_wins_hi", {32'd0, rd_data}, {32'd0, 32'h1234});
    waitDone("start_wins", bc, ok);
    if (ok) compareResult("start_wins");
    else void'(sbQ.pop_front());

    // Flush at RUN cycle 10: nothing committed, no done.
    tick(1);
    hilo_we    = 1'b1;
    hilo_wsel  = SEL_HI;
    hilo_wdata = 32'hAA;
    tick(1);
    hilo_wsel  = SEL_LO;
    hilo_wdata = 32'hBB;
    tick(1);
    hilo_we = 1'b0;
    op      = MD_MULT;
    src_a   = 32'h1234;
    src_b   = 32'd5;
    start   = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", {63'd0, busy}, 64'd0);
    readBoth("flush_hilo", 32'hAA, 32'hBB);
    doneSeen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || div_by_zero) doneSeen++;
    end
    checkOutput("flush_no_done", 64'(doneSeen), 64'd0);
    readBoth("flush_later", 32'hAA, 32'hBB);

    // Asynchronous reset mid-RUN.
    tick(1);
    op    = MD_DIVU;
    src_a = 32'd1000;
    src_b = 32'd3;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_busy", {63'd0, busy}, 64'd0);
    readBoth("rst_mid", 32'd0, 32'd0);
    tick(1);
    rst = 1'b1;
    tick(1);

    checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
